fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Tracks destination registers of instructions in EX and MEM via internal shadow slots.
- Produces registered forwarding selects (fa, fb) for the EX-stage ALU, whose single forward source is the EX/MEM ALU result.
- Produces stall/bubble controls for PC, IF/ID and ID/EX, and flush controls on a taken branch.

Parameters:
- REG_ADDR_W, 4, register-index width (16 architectural registers; R0 is an ordinary writable register, hazards apply to it).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  source A index of the ID instruction.
- id_rs2  in  REG_ADDR_W  source B / store-data index of the ID instruction.
- id_rs2_used  in  1  ID instruction reads rs2 (ALU operand or store data).
- id_rd  in  REG_ADDR_W  destination index of the ID instruction.
- id_reg_write  in  1  ID instruction writes id_rd at WB.
- id_mem_read  in  1  ID instruction is a load.
- ex_branch_taken  in  1  instruction in EX resolved a taken branch this cycle.
- fa  out  1  registered; EX ALU operand A takes the EX/MEM result.
- fb  out  1  registered; EX ALU operand B / store data takes the EX/MEM result.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_idex  out  1  combinational; load a NOP into ID/EX this cycle.
- flush_ifid  out  1  combinational; clear IF/ID.
- flush_idex  out  1  combinational; clear ID/EX.

Behaviour:
- Shadow slots ex_slot and mem_slot, each {valid, rd, reg_write, mem_read}.
  - Every edge: mem_slot <= ex_slot; ex_slot <= ID fields, or invalid when stall, flush or !id_valid.
- Match definitions, with rs = rs1 or (rs2 & id_rs2_used), and both requiring id_valid:
  - hit_ex(rs) = ex_slot.valid & ex_slot.reg_write & ex_slot.rd == rs.
  - hit_mem(rs) is the same test on mem_slot.
- stall = bubble_idex = !ex_branch_taken & ((hit_ex & ex_slot.mem_read) | hit_mem), evaluated over both sources.
- Next-cycle forwarding selects:
  - fa_next = hit_ex(rs1) & !ex_slot.mem_read; fb_next is the same test for rs2.
  - On each edge: fa <= fa_next and fb <= fb_next, unless stall or flush, in which case both load 0.
- Resulting latencies:
  - ALU→dependent at distance 1: zero stall, forward.
  - ALU at distance 2: 1 stall cycle.
  - Load at distance 1: 2 stall cycles.
  - Load at distance 2: 1 stall cycle.
  - The register file is write-first, so distance ≥3 needs nothing.
- Taken branch: flush_ifid = flush_idex = ex_branch_taken. Flush overrides stall in the same cycle, and ex_slot loads invalid.
- Both sources hitting: stall if either requires it; otherwise fa and fb are set independently.
- rs1 == rs2 with both hitting: fa = fb = 1.
- Reset (async, mid-operation included): slots invalid, fa = fb = 0, and combinational outputs 0 since all slots are invalid.
- No FSM beyond the shadow pipeline. Stall is recomputed every cycle, so durations emerge from slot advance with bubble insertion.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined:
  - Adds 32-bit outputs stall_cnt and flush_cnt, which count cycles with stall=1 and with ex_branch_taken=1.
  - Both counters saturate at all-ones and clear on reset.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg:
  - REG_ADDR_W constant.
  - hz_slot_t struct {valid, rd, reg_write, mem_read}.
  - HZ_SLOT_NONE constant.
- One natural sub-module, hz_src_match: given a source index and the two slots, returns hit_ex, hit_mem and ex_is_load. It is instantiated twice (rs1, rs2).

Test Plan:
- ADD r3 at EX (ex_slot rd=3, wr=1, load=0), ID reads rs1=3 → stall=0; after the edge fa=1, fb=0.
- LW r5 in EX, ID rs2=5 with id_rs2_used=1 → stall=1 for exactly 2 cycles (bubble_idex=1 both); fb=0 throughout; third cycle stall=0.
- ALU writes r7; one unrelated instruction; then a reader of r7 → 1 stall cycle when r7 is in mem_slot; fa=0 after.
- Load dependency plus ex_branch_taken=1 in the same cycle → stall=0, flush_ifid=flush_idex=1; next cycle fa=fb=0 and ex_slot invalid.
- rst_n driven low mid-stall (async, no clock edge) → fa, fb, stall, bubble_idex immediately 0; after release with no writers, no hazards are reported.
- HAZ_PERF_CNT_EN defined, load-use sequence plus one taken branch → stall_cnt=2, flush_cnt=1.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the 5-stage core hazard
//                logic: register-index width, the hazard shadow-slot record
//                and its empty value.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // 16 architectural registers; R0 is an ordinary writable register.
    localparam int REG_ADDR_W = 4;

    // One shadow slot tracking an in-flight instruction's write-back.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } hz_slot_t;

    localparam hz_slot_t HZ_SLOT_NONE = '{
        valid:     1'b0,
        rd:        '0,
        reg_write: 1'b0,
        mem_read:  1'b0
    };

endpackage
`default_nettype wire

// File: rtl/hz_src_match.sv
`default_nettype none
// ============================================================================
//  Module      : hz_src_match
//  Description : Compares one ID-stage source index against the EX and MEM
//                shadow slots and reports whether either slot will write it,
//                plus whether the EX-slot instruction is a load.
//  Revision    : 1.0 - initial release
// ============================================================================
module hz_src_match
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  rs_used_i,
    input  hz_slot_t              ex_slot_i,
    input  hz_slot_t              mem_slot_i,
    output logic                  hit_ex_o,
    output logic                  hit_mem_o,
    output logic                  ex_is_load_o
);

    // A hit needs a live source, a live writer slot and an index match.
    assign hit_ex_o     = rs_used_i & ex_slot_i.valid & ex_slot_i.reg_write
                        & (ex_slot_i.rd == rs_i);
    assign hit_mem_o    = rs_used_i & mem_slot_i.valid & mem_slot_i.reg_write
                        & (mem_slot_i.rd == rs_i);
    assign ex_is_load_o = ex_slot_i.mem_read;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_ctrl
//  Description : Forwarding / hazard controller for the 5-stage core.
//                Shadows the destinations of the EX and MEM instructions,
//                produces registered EX/MEM forwarding selects (fa, fb),
//                combinational stall/bubble controls, and branch flushes.
//                Optional macro HAZ_PERF_CNT_EN adds saturating 32-bit
//                stall_cnt / flush_cnt performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  fa,
    output logic                  fb,
    output logic                  stall,
    output logic                  bubble_idex,
    output logic                  flush_ifid,
    output logic                  flush_idex
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    import core_pkg::*;

    hz_slot_t ex_slot_q;
    hz_slot_t ex_slot_d;
    hz_slot_t mem_slot_q;
    logic     fa_q;
    logic     fa_d;
    logic     fb_q;
    logic     fb_d;

    logic     w_hit_ex_a;
    logic     w_hit_mem_a;
    logic     w_hit_ex_b;
    logic     w_hit_mem_b;
    logic     w_ex_load_a;
    logic     w_ex_load_b;
    logic     w_need_stall;
    logic     w_stall;
    logic     w_flush;

    hz_src_match u_match_rs1 (
        .rs_i         (id_rs1),
        .rs_used_i    (id_valid),
        .ex_slot_i    (ex_slot_q),
        .mem_slot_i   (mem_slot_q),
        .hit_ex_o     (w_hit_ex_a),
        .hit_mem_o    (w_hit_mem_a),
        .ex_is_load_o (w_ex_load_a)
    );

    hz_src_match u_match_rs2 (
        .rs_i         (id_rs2),
        .rs_used_i    (id_valid & id_rs2_used),
        .ex_slot_i    (ex_slot_q),
        .mem_slot_i   (mem_slot_q),
        .hit_ex_o     (w_hit_ex_b),
        .hit_mem_o    (w_hit_mem_b),
        .ex_is_load_o (w_ex_load_b)
    );

    // Stall when a load in EX or any writer in MEM feeds an ID source; the
    // MEM result cannot be forwarded, so distance-2 producers always wait.
    // A taken branch discards the ID instruction, so it overrides the stall.
    always_comb begin
        w_need_stall = (w_hit_ex_a & w_ex_load_a) | (w_hit_ex_b & w_ex_load_b)
                     | w_hit_mem_a | w_hit_mem_b;
        w_flush      = ex_branch_taken;
        w_stall      = w_need_stall & ~w_flush;

        if (w_stall || w_flush || !id_valid) begin
            ex_slot_d = HZ_SLOT_NONE;
        end else begin
            ex_slot_d = '{
                valid:     1'b1,
                rd:        id_rd,
                reg_write: id_reg_write,
                mem_read:  id_mem_read
            };
        end

        if (w_stall || w_flush) begin
            fa_d = 1'b0;
            fb_d = 1'b0;
        end else begin
            fa_d = w_hit_ex_a & ~w_ex_load_a;
            fb_d = w_hit_ex_b & ~w_ex_load_b;
        end
    end

    // Advance the shadow pipeline and register the forwarding selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot_q  <= HZ_SLOT_NONE;
            mem_slot_q <= HZ_SLOT_NONE;
            fa_q       <= 1'b0;
            fb_q       <= 1'b0;
        end else begin
            ex_slot_q  <= ex_slot_d;
            mem_slot_q <= ex_slot_q;
            fa_q       <= fa_d;
            fb_q       <= fb_d;
        end
    end

    assign fa          = fa_q;
    assign fb          = fb_q;
    assign stall       = w_stall;
    assign bubble_idex = w_stall;
    assign flush_ifid  = w_flush;
    assign flush_idex  = w_flush;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters for stall cycles and taken-branch cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (w_stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (w_flush && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_ctrl
//  Description : Self-checking bench for fwd_hazard_ctrl: directed hazard
//                scenarios plus randomized traffic against an in-flight
//                instruction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic       id_rs2_used;
    logic [3:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_branch_taken;
    logic       fa;
    logic       fb;
    logic       stall;
    logic       bubble_idex;
    logic       flush_ifid;
    logic       flush_idex;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(.REG_ADDR_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .fa              (fa),
        .fb              (fb),
        .stall           (stall),
        .bubble_idex     (bubble_idex),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                            input logic used2, input logic [3:0] rd, input logic wr,
                            input logic ld, input logic br);
        id_valid        = v;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rs2_used     = used2;
        id_rd           = rd;
        id_reg_write    = wr;
        id_mem_read     = ld;
        ex_branch_taken = br;
    endtask

    task automatic idle(input int n);
        drive_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_id(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        #12;
        checks++;
        if ({fa, fb, stall, bubble_idex, flush_ifid, flush_idex} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {fa, fb, stall, bubble_idex, flush_ifid, flush_idex});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_alu_forward();
        drive_id(1'b1, 4'd9, 4'd10, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 4'd3, 4'd4, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd_stall: got %b expected 0", stall);
        end
        step();
        checks++;
        if ({fa, fb} !== 2'b10) begin
            errors++;
            $display("FAIL alu_fwd_sel: got fa,fb=%b expected 10", {fa, fb});
        end
        idle(3);
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 4'd1, 4'd5, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({stall, bubble_idex} !== 2'b11) begin
            errors++;
            $display("FAIL load_use_c1: got stall,bubble=%b expected 11", {stall, bubble_idex});
        end
        step();
        checks++;
        if ({stall, bubble_idex, fb} !== 3'b110) begin
            errors++;
            $display("FAIL load_use_c2: got stall,bubble,fb=%b expected 110",
                     {stall, bubble_idex, fb});
        end
        step();
        checks++;
        if ({stall, bubble_idex, fb} !== 3'b000) begin
            errors++;
            $display("FAIL load_use_c3: got stall,bubble,fb=%b expected 000",
                     {stall, bubble_idex, fb});
        end
        idle(3);
    endtask

    task automatic test_alu_dist2();
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 4'd7, 4'd2, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL alu_dist2_stall: got %b expected 1", stall);
        end
        step();
        checks++;
        if ({stall, fa} !== 2'b00) begin
            errors++;
            $display("FAIL alu_dist2_after: got stall,fa=%b expected 00", {stall, fa});
        end
        idle(3);
    endtask

    task automatic test_branch_flush();
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step();
        // Dependent ID instruction that is itself a load of r9, plus a taken branch.
        drive_id(1'b1, 4'd5, 4'd5, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if ({stall, bubble_idex, flush_ifid, flush_idex} !== 4'b0011) begin
            errors++;
            $display("FAIL branch_flush: got stall,bubble,fifid,fidex=%b expected 0011",
                     {stall, bubble_idex, flush_ifid, flush_idex});
        end
        step();
        // A reader of r9 would stall if the flushed load had entered EX.
        drive_id(1'b1, 4'd9, 4'd9, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({fa, fb, stall, flush_ifid} !== 4'b0000) begin
            errors++;
            $display("FAIL branch_after: got fa,fb,stall,flush=%b expected 0000",
                     {fa, fb, stall, flush_ifid});
        end
        idle(3);
    endtask

    task automatic test_async_reset();
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 4'd3, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 4'd1, 4'd5, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({fa, stall} !== 2'b11) begin
            errors++;
            $display("FAIL async_pre: got fa,stall=%b expected 11", {fa, stall});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fa, fb, stall, bubble_idex} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got fa,fb,stall,bubble=%b expected 0000",
                     {fa, fb, stall, bubble_idex});
        end
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if ({fa, fb, stall, bubble_idex} !== 4'b0000) begin
            errors++;
            $display("FAIL async_release: got fa,fb,stall,bubble=%b expected 0000",
                     {fa, fb, stall, bubble_idex});
        end
        idle(3);
    endtask

    task automatic test_both_sources();
        drive_id(1'b1, 4'd1, 4'd1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 4'd2, 4'd2, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL both_src_stall: got %b expected 0", stall);
        end
        step();
        checks++;
        if ({fa, fb} !== 2'b11) begin
            errors++;
            $display("FAIL both_src_sel: got fa,fb=%b expected 11", {fa, fb});
        end
        idle(3);
    endtask

    typedef struct {
        logic [3:0] rd;
        bit         wr;
        bit         ld;
        int         age;
    } inst_t;

    // Random traffic against a model of in-flight producers keyed by age
    // (1 = issued last cycle, 2 = issued two cycles ago).
    task automatic test_random();
        inst_t q[$];
        bit    m_fa;
        bit    m_fb;
        bit    need;
        bit    fwd_a;
        bit    fwd_b;
        bit    m_stall;
        bit    v;
        bit    u2;
        bit    br;
        logic [3:0] rs1;
        logic [3:0] rs2;
        inst_t n;
        m_fa = 1'b0;
        m_fb = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            u2  = $urandom_range(0, 1);
            br  = ($urandom_range(0, 7) == 0);
            rs1 = 4'($urandom_range(0, 3));
            rs2 = 4'($urandom_range(0, 3));
            drive_id(v, rs1, rs2, u2, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), br);
            need  = 1'b0;
            fwd_a = 1'b0;
            fwd_b = 1'b0;
            foreach (q[i]) begin
                if (q[i].wr && v && q[i].rd == rs1) begin
                    if (q[i].age == 1 && !q[i].ld) fwd_a = 1'b1;
                    else need = 1'b1;
                end
                if (q[i].wr && v && u2 && q[i].rd == rs2) begin
                    if (q[i].age == 1 && !q[i].ld) fwd_b = 1'b1;
                    else need = 1'b1;
                end
            end
            m_stall = need && !br;
            #1;
            checks++;
            if ({stall, bubble_idex, flush_ifid, flush_idex, fa, fb} !==
                {m_stall, m_stall, br, br, m_fa, m_fb}) begin
                errors++;
                $display("FAIL random_c%0d: got st,bub,fi,fe,fa,fb=%b expected %b", c,
                         {stall, bubble_idex, flush_ifid, flush_idex, fa, fb},
                         {m_stall, m_stall, br, br, m_fa, m_fb});
            end
            m_fa = !(m_stall || br) && fwd_a;
            m_fb = !(m_stall || br) && fwd_b;
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age > 2) void'(q.pop_front());
            if (v && !m_stall && !br) begin
                n.rd  = id_rd;
                n.wr  = id_reg_write;
                n.ld  = id_mem_read;
                n.age = 1;
                q.push_back(n);
            end
            step();
        end
        idle(3);
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        idle(1);
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 4'd1, 4'd5, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drive_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        idle(2);
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
        end
        checks++;
        if (flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL flush_cnt: got %0d expected 1", flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_alu_dist2();
        test_branch_flush();
        test_async_reset();
        test_both_sources();
        test_random();
`ifdef HAZ_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
